// File: rtl/divider_8b.sv
// Restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module divider_8b #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int QW = 2 * WIDTH;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state;
  logic [QW-1:0]     q_sr;
  logic [WIDTH-1:0]  d_reg;
  logic [WIDTH-1:0]  r_reg;
  logic [CW-1:0]     cnt;

  logic [WIDTH:0]    t;
  logic              ge;
  logic [WIDTH-1:0]  r_nxt;
  logic [QW-1:0]     q_nxt;
  logic              last;

  // R stays below D, so its top bit is always zero and is not stored.
  always_comb begin
    t     = {r_reg, q_sr[QW-1]};
    ge    = t >= {1'b0, d_reg};
    r_nxt = ge ? WIDTH'(t - {1'b0, d_reg})
               : t[WIDTH-1:0];
    q_nxt = {q_sr[QW-2:0], ge};
    last  = cnt == CW'(QW - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q_sr        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              q_sr        <= dividend;
              d_reg       <= divisor;
              r_reg       <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              overflow    <= dividend[QW-1:WIDTH] >= divisor;
              state       <= BUSY;
            end
          end
        end
        BUSY: begin
          q_sr  <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/divider_8b.md
# divider_8b

Sequential restoring divider that inverts the 4×4 array multiplier. It takes an 8-bit dividend (a product word) and a 4-bit divisor (one operand), and returns the 8-bit quotient and 4-bit remainder. One quotient bit is produced per clock, and it uses a valid/ready handshake on both sides. It sits downstream of the multiplier in the arithmetic-tree verification datapath, and also serves as a standalone divide unit.

## Interface
- WIDTH, 4, divisor/remainder width; dividend and quotient are 2*WIDTH bits.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  divider idle, can accept operands.
- dividend  input  2*WIDTH  numerator, unsigned.
- divisor  input  WIDTH  denominator, unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- quotient  output  2*WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  divisor was 0.
- overflow  output  1  quotient ≥ 2^WIDTH, so the dividend is not a WIDTH×WIDTH product with this divisor.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: 2*WIDTH iterations.
  - DONE: out_valid=1.
- IDLE→BUSY on in_valid&&in_ready with divisor≠0.
  - Capture: dividend into Q shift register, divisor into D, partial remainder R (WIDTH+1 bits) ← 0, iteration counter ← 0.
  - overflow ← (dividend[2*WIDTH-1:WIDTH] ≥ divisor).
- IDLE→DONE on accept with divisor==0.
  - quotient ← all ones (8'hFF), remainder ← dividend[WIDTH-1:0].
  - div_by_zero ← 1, overflow ← 0.
- BUSY, each cycle:
  - T = {R[WIDTH-1:0], Q[MSB]}; Q shifts left.
  - If T ≥ D: R ← T−D and new Q LSB=1. Else R ← T and new Q LSB=0.
  - Counter increments. The iteration with counter==2*WIDTH−1 transitions to DONE.
- DONE: quotient=Q, remainder=R[WIDTH-1:0]. On out_ready → IDLE.
- Hold rules:
  - Outputs and flags hold stable while out_valid && !out_ready.
  - Operand inputs are ignored outside IDLE; one operation in flight at a time.
  - Operands need only be valid on the accept cycle.
- Invariant for divisor≠0: dividend == quotient*divisor + remainder and remainder < divisor. This holds for every 8-bit dividend, including when overflow=1.
- Reset values (rst high at a clock edge):
  - State IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, overflow=0.
- Reset mid-operation (BUSY or DONE): the operation is discarded with no result emitted. The reset values above apply after that edge.
- rst has priority over a simultaneous in_valid or out_ready.

## Timing
- Accept at edge E0 (in_valid&&in_ready sampled high).
- Normal: in_ready low from E0. Iterations occur at edges E1..E2*WIDTH. out_valid is high after edge E8 (WIDTH=4), i.e. 8-cycle latency.
- Divide-by-zero: out_valid is high after E0, i.e. 1-cycle latency.
- Result transfer at edge Ex where out_valid&&out_ready. After Ex: out_valid=0 and in_ready=1.
- Earliest next accept is edge Ex+1. in_valid held high across Ex is not accepted at Ex.
- Back-to-back throughput: one operation per 10 cycles with out_ready tied high.
- quotient, remainder and flags change only on the capture edge, on the final iteration edge, and on reset. Intermediate Q/R are not visible on the outputs.
- in_ready and out_valid are registered state decodes; neither depends combinationally on any input.

## Test plan
- 143/11 (8'h8F, 4'hB), out_ready=1 → after 8 cycles quotient=13, remainder=0, overflow=0, div_by_zero=0; in_ready returns the cycle after transfer.
- 225/15 (8'hE1, 4'hF) → quotient=15, remainder=0, overflow=0; exhaustive sweep of all 4×4 products a*b with b≠0 returns quotient=a, remainder=0.
- 200/3 → quotient=66, remainder=2, overflow=1; random sweep checks dividend==q*d+r and r<d.
- 77/0 (8'h4D) → out_valid one cycle after accept, quotient=8'hFF, remainder=4'hD, div_by_zero=1, overflow=0.
- 100/7 with out_ready low 5 cycles after out_valid → quotient=14, remainder=2 held stable; in_ready=0 throughout; in_valid pulses during the stall are ignored; transfer on release.
- rst asserted at the 4th BUSY cycle of 255/1 → next cycle in_ready=1, out_valid=0, outputs 0; follow-up 100/7 yields quotient=14, remainder=2 with no stale result.
